// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative binary-to-packed-BCD converter (double dabble).
// Processes one input bit per clock. A start/done handshake frames each conversion.
// Converts the ALU result into digits for the 7-segment display driver.
// Optional feature macro: OVERFLOW_CHECK_EN.
//   When it is defined, inputs above 10^DIGITS-1 raise ovf and saturate bcd to all 9s.
//   When it is undefined, ovf is tied low and bcd is bin mod 10^DIGITS.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Per-digit correction: any digit of 5 or more gets +3 before the shift.
  // The add is confined to its own nibble, so no carry passes between digits.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    logic [3:0]       d;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      d = s[4*i +: 4];
      r[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
    return r;
  endfunction

`ifdef OVERFLOW_CHECK_EN
  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam logic [63:0]      LIMIT = 64'(pow10(DIGITS) - 1);
  localparam logic [BCD_W-1:0] ALL9  = {DIGITS{4'h9}};
`endif

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   shifted;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef OVERFLOW_CHECK_EN
  logic               ovf_pend_q, ovf_pend_d;
  logic               ovf_q, ovf_d;
`endif

  // Next-state and datapath logic for the IDLE -> SHIFT -> DONE sequence.
  // The registered outputs are computed from the next state.
  // As a result, done, busy and the new bcd are all visible in the DONE cycle.
  always_comb begin
    // NOTE: every signal gets a default here first; any path that left one unassigned would infer a latch.
    state_d     = state_q;
    shreg_d     = shreg_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    scratch_adj = add3(scratch_q);
    shifted     = {scratch_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
`ifdef OVERFLOW_CHECK_EN
    ovf_pend_d  = ovf_pend_q;
    ovf_d       = ovf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = S_SHIFT;
`ifdef OVERFLOW_CHECK_EN
          // Decide overflow at capture time. Later shifts destroy the operand.
          ovf_pend_d = (64'(bin) > LIMIT);
`endif
        end
      end

      S_SHIFT: begin
        // Correct the digits, then shift {scratch, shreg} left by one bit.
        // Bits that leave the top digit are dropped.
        scratch_d = shifted;
        shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = S_DONE;
`ifdef OVERFLOW_CHECK_EN
          bcd_d   = ovf_pend_q ? ALL9 : shifted;
          ovf_d   = ovf_pend_q;
`else
          bcd_d   = shifted;
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  // A synchronous reset overrides everything, including a conversion in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef OVERFLOW_CHECK_EN
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef OVERFLOW_CHECK_EN
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef OVERFLOW_CHECK_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq (BIN_W=14, DIGITS=4).
// Table-driven conversions plus hand-written sequences for reset, ignored start and back-to-back operation.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, independent of the shift algorithm.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int x;
`ifdef OVERFLOW_CHECK_EN
    if (v > 9999) return 16'h9999;
`endif
    x = v % 10000;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Call this at the sample point right after the acceptance edge (c=0).
  // It returns the sample index at which done was seen (-1 on timeout) and the number of busy samples.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cycles++;
      if (done) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic run_conv(input logic [13:0] v, input logic [15:0] exp_bcd,
                          input logic exp_ovf, input string name);
    int lat;
    int bc;
    logic [15:0] got;
    bin = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin = ~v;                      // must have no effect after acceptance
    wait_done(lat, bc);
    check({name, " latency"}, lat, 14);
    check({name, " busy_cycles"}, bc, 15);
    check({name, " bcd"}, bcd, exp_bcd);
    check({name, " ovf"}, ovf, exp_ovf);
    got = bcd;
    tick();
    check({name, " done_single"}, done, 1'b0);
    check({name, " busy_after"}, busy, 1'b0);
    check({name, " bcd_held"}, bcd, got);
  endtask

  initial begin
    vec_t vecs[14];
    int   lat;
    int   bc;
    int   k;
    int   pulses;

    vecs[0]  = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
    vecs[1]  = '{bin: 14'd1,     bcd: 16'h0001, ovf: 1'b0};
    vecs[2]  = '{bin: 14'd9,     bcd: 16'h0009, ovf: 1'b0};
    vecs[3]  = '{bin: 14'd10,    bcd: 16'h0010, ovf: 1'b0};
    vecs[4]  = '{bin: 14'd99,    bcd: 16'h0099, ovf: 1'b0};
    vecs[5]  = '{bin: 14'd100,   bcd: 16'h0100, ovf: 1'b0};
    vecs[6]  = '{bin: 14'd1234,  bcd: 16'h1234, ovf: 1'b0};
    vecs[7]  = '{bin: 14'd5678,  bcd: 16'h5678, ovf: 1'b0};
    vecs[8]  = '{bin: 14'd4095,  bcd: 16'h4095, ovf: 1'b0};
    vecs[9]  = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
`ifdef OVERFLOW_CHECK_EN
    vecs[10] = '{bin: 14'd10000, bcd: 16'h9999, ovf: 1'b1};
    vecs[11] = '{bin: 14'd12345, bcd: 16'h9999, ovf: 1'b1};
    vecs[12] = '{bin: 14'd16383, bcd: 16'h9999, ovf: 1'b1};
`else
    vecs[10] = '{bin: 14'd10000, bcd: 16'h0000, ovf: 1'b0};
    vecs[11] = '{bin: 14'd12345, bcd: 16'h2345, ovf: 1'b0};
    vecs[12] = '{bin: 14'd16383, bcd: 16'h6383, ovf: 1'b0};
`endif
    vecs[13] = '{bin: 14'd8192,  bcd: 16'h8192, ovf: 1'b0};

    // Reset state
    rst = 1'b1;
    start = 1'b0;
    bin = '0;
    tick();
    tick();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset bcd", bcd, 16'h0000);
    check("reset ovf", ovf, 1'b0);
    rst = 1'b0;
    tick();

    // Table-driven conversions
    for (int i = 0; i < 14; i++) begin
      run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Reset asserted for 2 cycles in the middle of SHIFT
    bin = 14'd777;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("midreset busy", busy, 1'b0);
    check("midreset done", done, 1'b0);
    check("midreset bcd", bcd, 16'h0000);
    check("midreset ovf", ovf, 1'b0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done) pulses++;
    end
    check("midreset no_done", pulses, 0);
    run_conv(14'd777, 16'h0777, 1'b0, "post_reset");

    // A start pulse during SHIFT is ignored
    bin = 14'd1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bin = 14'd42;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bc);
    check("ignored_start latency", lat, 9);
    check("ignored_start bcd", bcd, 16'h1234);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done) pulses++;
    end
    check("ignored_start no_extra_done", pulses, 0);
    check("ignored_start bcd_held", bcd, 16'h1234);

    // Back-to-back sweep with start held high and a 1-cycle IDLE gap between results
    start = 1'b1;
    for (int i = 0; i <= 303; i++) begin
      bin = 14'(i * 33);
      k = 0;
      for (int c = 1; c <= 4; c++) begin
        tick();
        if (busy) begin
          k = c;
          break;
        end
      end
      check($sformatf("sweep%0d accept_delay", i), k, 1);
      wait_done(lat, bc);
      check($sformatf("sweep%0d latency", i), lat, 14);
      check($sformatf("sweep%0d bcd", i), bcd, ref_bcd(i * 33));
      tick();
      check($sformatf("sweep%0d idle_gap", i), busy, 1'b0);
    end
    start = 1'b0;
    repeat (20) tick();
    check("sweep end idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
